mem_align_unit: RTL and testbench

//  Memory-stage load/store alignment engine; parametrised successor to the CPU's combinational load extender.

---
 rtl/mem_align_pkg.sv | 32 +++
 rtl/mem_load_ext.sv | 32 +++
 rtl/mem_align_unit.sv | 167 ++++++++++++++++
 tb/tb_mem_align_unit.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_align_pkg.sv
// Shared encodings for the memory-stage alignment engine: access sizes,
// FSM states and the per-size byte mask helper.
package mem_align_pkg;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;
  localparam logic [1:0] SIZE_D = 2'd3;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    B0   = 3'd1,
    B1   = 3'd2,
    WT   = 3'd3,
    RESP = 3'd4
  } state_t;

  // Right-justified byte mask for an access of the given size.
  function automatic logic [7:0] byte_mask(input logic [1:0] size);
    case (size)
      SIZE_B:  byte_mask = 8'h01;
      SIZE_H:  byte_mask = 8'h03;
      SIZE_W:  byte_mask = 8'h0F;
      default: byte_mask = 8'hFF;
    endcase
  endfunction

  function automatic logic [3:0] byte_count(input logic [1:0] size);
    byte_count = 4'd1 << size;
  endfunction

endpackage

// File: rtl/mem_load_ext.sv
// Combinational load merge: shifts the two-beat window {rd1,rd0} down by the
// byte offset, keeps the accessed bytes and sign/zero-extends them.
module mem_load_ext #(
  parameter int DATA_W = 32,
  parameter int OW     = $clog2(DATA_W / 8)
) (
  input  logic [DATA_W-1:0] rd0_i,
  input  logic [DATA_W-1:0] rd1_i,
  input  logic [OW-1:0]     off_i,
  input  logic [1:0]        size_i,
  input  logic              sgn_i,
  output logic [DATA_W-1:0] data_o
);

  logic [2*DATA_W-1:0] merged;
  logic [DATA_W-1:0]   low;
  logic [DATA_W-1:0]   hi_mask;
  logic [DATA_W-1:0]   top_bit;
  logic                sbit;

  // Shifts by >= DATA_W yield zero, so full-width loads get an empty
  // extension mask and pass through untouched.
  always_comb begin
    merged  = {rd1_i, rd0_i} >> (8 * off_i);
    low     = merged[DATA_W-1:0];
    hi_mask = {DATA_W{1'b1}} << (8 << size_i);
    top_bit = {{(DATA_W-1){1'b0}}, 1'b1} << ((8 << size_i) - 1);
    sbit    = sgn_i & (|(low & top_bit));
    data_o  = (low & ~hi_mask) | (sbit ? hi_mask : '0);
  end

endmodule

// File: rtl/mem_align_unit.sv
// Load/store alignment engine: turns one B/H/W/D access into one or two
// byte-enabled beats on a 1-cycle sync RAM and returns extended load data.
module mem_align_unit
  import mem_align_pkg::*;
#(
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 32,
  parameter bit ALLOW_MISALIGN = 1'b1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [1:0]          req_size,
  input  logic                req_signed,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_exc,
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int NB = DATA_W / 8;
  localparam int OW = $clog2(NB);

  if (DATA_W != 32 && DATA_W != 64) begin : g_bad_width
    $error("mem_align_unit: DATA_W must be 32 or 64");
  end

  state_t              state_q, state_d;
  logic                we_q, sgn_q, exc_q, split_q;
  logic [1:0]          size_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q, rd0_q, rdata_q;

  logic                accept, req_illegal, req_mis, req_split, req_exc;
  logic [OW-1:0]       req_off;
  logic [3:0]          req_nb;

  always_comb begin
    accept      = req_valid & req_ready;
    req_off     = req_addr[OW-1:0];
    req_nb      = byte_count(req_size);
    req_illegal = (DATA_W == 32) && (req_size == SIZE_D);
    req_mis     = |(4'(req_off) & (req_nb - 4'd1));
    req_split   = (4'(req_off) + req_nb) > 4'(NB);
    req_exc     = req_illegal || (req_mis && !ALLOW_MISALIGN);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = req_exc ? RESP : B0;
      B0:      state_d = split_q ? B1 : WT;
      B1:      state_d = WT;
      WT:      state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Beat geometry: the access window is laid over two adjacent lanes, the
  // low half goes out on B0 and the spill-over on B1.
  logic [OW-1:0]         off;
  logic [ADDR_W-1:0]     base;
  logic [7:0]            mask8;
  logic [2*NB-1:0]       be_wide;
  logic [2*DATA_W-1:0]   wd_wide;

  always_comb begin
    off     = addr_q[OW-1:0];
    base    = {addr_q[ADDR_W-1:OW], {OW{1'b0}}};
    mask8   = byte_mask(size_q);
    be_wide = {{NB{1'b0}}, mask8[NB-1:0]} << off;
    wd_wide = {{DATA_W{1'b0}}, wdata_q} << (8 * off);
  end

  always_comb begin
    req_ready = (state_q == IDLE);
    rsp_valid = (state_q == RESP);
    rsp_exc   = rsp_valid & exc_q;
    rsp_rdata = rsp_valid ? rdata_q : '0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_be    = '0;
    mem_wdata = '0;
    case (state_q)
      B0: begin
        mem_en    = 1'b1;
        mem_we    = we_q;
        mem_addr  = base;
        mem_be    = be_wide[NB-1:0];
        mem_wdata = wd_wide[DATA_W-1:0];
      end
      B1: begin
        mem_en    = 1'b1;
        mem_we    = we_q;
        mem_addr  = base + ADDR_W'(NB);
        mem_be    = be_wide[2*NB-1:NB];
        mem_wdata = wd_wide[2*DATA_W-1:DATA_W];
      end
      default: ;
    endcase
  end

  // In WT the RAM is presenting the last beat; earlier beat came from rd0_q.
  logic [DATA_W-1:0] rd0_sel, rd1_sel, ext_data;

  always_comb begin
    rd0_sel = split_q ? rd0_q : mem_rdata;
    rd1_sel = split_q ? mem_rdata : '0;
  end

  mem_load_ext #(
    .DATA_W (DATA_W),
    .OW     (OW)
  ) u_ext (
    .rd0_i  (rd0_sel),
    .rd1_i  (rd1_sel),
    .off_i  (off),
    .size_i (size_q),
    .sgn_i  (sgn_q),
    .data_o (ext_data)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      we_q    <= 1'b0;
      sgn_q   <= 1'b0;
      exc_q   <= 1'b0;
      split_q <= 1'b0;
      size_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rd0_q   <= '0;
      rdata_q <= '0;
    end else begin
      if (accept) begin
        we_q    <= req_we;
        sgn_q   <= req_signed;
        exc_q   <= req_exc;
        split_q <= req_split;
        size_q  <= req_size;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        rdata_q <= '0;
      end
      if (state_q == B1) rd0_q <= mem_rdata;
      if (state_q == WT) rdata_q <= we_q ? '0 : ext_data;
    end
  end

endmodule

// File: tb/tb_mem_align_unit.sv
// Bench for mem_align_unit: two instances (misalign served / trapped) on
// behavioural sync RAMs, table-driven accesses plus stall and reset sequences.
module tb_mem_align_unit;

  localparam int DW = 32;
  localparam int AW = 32;

  typedef struct {
    bit        we;
    bit [1:0]  size;
    bit        sgn;
    bit [31:0] addr;
    bit [31:0] wdata;
    bit [31:0] exp;
    bit        exc;
    int        lat;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        exc;
    int          lat;
  } sb_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n, req_valid, req_we, req_signed, rsp_ready;
  logic [1:0]    req_size;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;

  logic          a_req_ready, a_rsp_valid, a_rsp_exc, a_mem_en, a_mem_we;
  logic [DW-1:0] a_rsp_rdata, a_mem_wdata, a_mem_rdata;
  logic [AW-1:0] a_mem_addr;
  logic [3:0]    a_mem_be;
  logic          x_req_ready, x_rsp_valid, x_rsp_exc, x_mem_en, x_mem_we;
  logic [DW-1:0] x_rsp_rdata, x_mem_wdata, x_mem_rdata;
  logic [AW-1:0] x_mem_addr;
  logic [3:0]    x_mem_be;

  mem_align_unit #(.DATA_W(DW), .ADDR_W(AW), .ALLOW_MISALIGN(1'b1)) u_a (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(a_req_ready),
    .req_we(req_we), .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(a_rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(a_rsp_rdata), .rsp_exc(a_rsp_exc), .mem_en(a_mem_en), .mem_we(a_mem_we),
    .mem_addr(a_mem_addr), .mem_be(a_mem_be), .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata)
  );

  mem_align_unit #(.DATA_W(DW), .ADDR_W(AW), .ALLOW_MISALIGN(1'b0)) u_x (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(x_req_ready),
    .req_we(req_we), .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(x_rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(x_rsp_rdata), .rsp_exc(x_rsp_exc), .mem_en(x_mem_en), .mem_we(x_mem_we),
    .mem_addr(x_mem_addr), .mem_be(x_mem_be), .mem_wdata(x_mem_wdata), .mem_rdata(x_mem_rdata)
  );

  // Behavioural 1-cycle sync RAMs, 64 words each (address bits [7:2]).
  logic        preload;
  logic [31:0] img   [0:63];
  logic [31:0] ram_a [0:63];
  logic [31:0] ram_x [0:63];

  always @(posedge clk) begin
    if (preload) begin
      ram_a <= img;
      ram_x <= img;
    end else begin
      if (a_mem_en) begin
        if (a_mem_we) begin
          for (int b = 0; b < 4; b++)
            if (a_mem_be[b]) ram_a[a_mem_addr[7:2]][8*b +: 8] <= a_mem_wdata[8*b +: 8];
        end else a_mem_rdata <= ram_a[a_mem_addr[7:2]];
      end
      if (x_mem_en) begin
        if (x_mem_we) begin
          for (int b = 0; b < 4; b++)
            if (x_mem_be[b]) ram_x[x_mem_addr[7:2]][8*b +: 8] <= x_mem_wdata[8*b +: 8];
        end else x_mem_rdata <= ram_x[x_mem_addr[7:2]];
      end
    end
  end

  int          n_chk = 0;
  int          n_err = 0;
  sb_t         exp_q[$];
  int          nbeats;
  logic [31:0] b_addr [4];
  logic [31:0] b_wd   [4];
  logic [3:0]  b_be   [4];
  logic        b_we   [4];
  vec_t        vt     [19];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_chk++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp_v);
    end
  endtask

  // Issue one access to both instances, observe the selected one until it
  // responds, logging every beat it drives; then wait until both are idle.
  task automatic do_req(input bit sel, input vec_t v, input string nm);
    sb_t e;
    int  lat_n, n;
    bit  got;
    exp_q.push_back('{v.exp, v.exc, v.lat});
    nbeats     = 0;
    req_we     = v.we;
    req_size   = v.size;
    req_signed = v.sgn;
    req_addr   = v.addr;
    req_wdata  = v.wdata;
    rsp_ready  = 1'b1;
    req_valid  = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat_n = 0;
    got   = 1'b0;
    while (!got && lat_n < 20) begin
      @(negedge clk);
      lat_n++;
      if ((sel ? x_mem_en : a_mem_en) && nbeats < 4) begin
        b_addr[nbeats] = sel ? x_mem_addr  : a_mem_addr;
        b_wd[nbeats]   = sel ? x_mem_wdata : a_mem_wdata;
        b_be[nbeats]   = sel ? x_mem_be    : a_mem_be;
        b_we[nbeats]   = sel ? x_mem_we    : a_mem_we;
        nbeats++;
      end
      if (sel ? x_rsp_valid : a_rsp_valid) got = 1'b1;
    end
    e = exp_q.pop_front();
    check($sformatf("%s valid", nm), 32'(got), 32'd1);
    check($sformatf("%s latency", nm), 32'(lat_n), 32'(e.lat));
    check($sformatf("%s rdata", nm), sel ? x_rsp_rdata : a_rsp_rdata, e.rdata);
    check($sformatf("%s exc", nm), 32'(sel ? x_rsp_exc : a_rsp_exc), 32'(e.exc));
    check($sformatf("%s beats", nm), 32'(nbeats), (e.lat == 4) ? 32'd2 : (e.lat == 3) ? 32'd1 : 32'd0);
    n = 0;
    while (!(a_req_ready && x_req_ready) && n < 20) begin
      @(posedge clk);
      #1 n++;
    end
    if (n >= 20) begin
      n_chk++;
      n_err++;
      $display("FAIL %s drain: units not idle after %0d cycles", nm, n);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int n;
    reset_n    = 1'b0;
    preload    = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_size   = 2'd0;
    req_signed = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    rsp_ready  = 1'b1;

    for (int i = 0; i < 64; i++) img[i] = 32'h0;
    img[0]  = 32'h4433_2211;
    img[4]  = 32'h80FF_0000;
    img[5]  = 32'h0000_00A5;
    img[7]  = 32'hBEEF_1234;
    img[8]  = 32'h1111_1111;
    img[9]  = 32'h2222_2222;
    img[63] = 32'hDDCC_BBAA;

    //        we  size  sgn  addr          wdata          exp            exc lat
    vt[0]  = '{0, 2'd0, 1, 32'h0000_0013, 32'h0,         32'hFFFF_FF80, 0, 3};
    vt[1]  = '{0, 2'd0, 0, 32'h0000_0013, 32'h0,         32'h0000_0080, 0, 3};
    vt[2]  = '{0, 2'd1, 0, 32'h0000_001E, 32'h0,         32'h0000_BEEF, 0, 3};
    vt[3]  = '{0, 2'd1, 1, 32'h0000_001E, 32'h0,         32'hFFFF_BEEF, 0, 3};
    vt[4]  = '{0, 2'd2, 0, 32'h0000_0010, 32'h0,         32'h80FF_0000, 0, 3};
    vt[5]  = '{0, 2'd0, 1, 32'h0000_0012, 32'h0,         32'hFFFF_FFFF, 0, 3};
    vt[6]  = '{0, 2'd1, 1, 32'h0000_0011, 32'h0,         32'hFFFF_FF00, 0, 3};
    vt[7]  = '{1, 2'd2, 0, 32'h0000_000B, 32'h1122_3344, 32'h0,         0, 4};
    vt[8]  = '{0, 2'd2, 0, 32'h0000_000B, 32'h0,         32'h1122_3344, 0, 4};
    vt[9]  = '{0, 2'd1, 1, 32'h0000_0013, 32'h0,         32'hFFFF_A580, 0, 4};
    vt[10] = '{0, 2'd1, 0, 32'h0000_0013, 32'h0,         32'h0000_A580, 0, 4};
    vt[11] = '{1, 2'd0, 0, 32'h0000_0021, 32'hFFFF_FFAB, 32'h0,         0, 3};
    vt[12] = '{1, 2'd1, 0, 32'h0000_0023, 32'h0000_CAFE, 32'h0,         0, 4};
    vt[13] = '{0, 2'd2, 0, 32'h0000_0020, 32'h0,         32'hFE11_AB11, 0, 3};
    vt[14] = '{0, 2'd2, 0, 32'h0000_0024, 32'h0,         32'h2222_22CA, 0, 3};
    vt[15] = '{0, 2'd3, 0, 32'h0000_0010, 32'h0,         32'h0,         1, 1};
    vt[16] = '{0, 2'd2, 0, 32'hFFFF_FFFE, 32'h0,         32'h2211_DDCC, 0, 4};
    vt[17] = '{0, 2'd2, 1, 32'h0000_0010, 32'h0,         32'h80FF_0000, 0, 3};
    vt[18] = '{0, 2'd0, 1, 32'h0000_001C, 32'h0,         32'h0000_0034, 0, 3};

    #1;
    check("reset req_ready", 32'(a_req_ready), 32'd1);
    check("reset rsp", {29'd0, a_rsp_valid, a_rsp_exc, a_mem_en}, 32'd0);
    check("reset mem_we/be", {27'd0, a_mem_we, a_mem_be}, 32'd0);
    check("reset mem_addr", a_mem_addr, 32'd0);
    check("reset mem_wdata", a_mem_wdata, 32'd0);
    check("reset rsp_rdata", a_rsp_rdata, 32'd0);

    @(posedge clk);
    #1 preload = 1'b0;
    @(posedge clk);
    #1 reset_n = 1'b1;

    for (int i = 0; i < 19; i++) begin
      do_req(1'b0, vt[i], $sformatf("vec%0d", i));
      if (i == 7) begin
        check("sw B0 addr", b_addr[0], 32'h0000_0008);
        check("sw B0 be", 32'(b_be[0]), 32'h8);
        check("sw B0 wdata", b_wd[0], 32'h4400_0000);
        check("sw B0 we", 32'(b_we[0]), 32'd1);
        check("sw B1 addr", b_addr[1], 32'h0000_000C);
        check("sw B1 be", 32'(b_be[1]), 32'h7);
        check("sw B1 wdata", b_wd[1], 32'h0011_2233);
      end
      if (i == 2) check("lhu be", 32'(b_be[0]), 32'hC);
      if (i == 16) begin
        check("wrap B0 addr", b_addr[0], 32'hFFFF_FFFC);
        check("wrap B1 addr", b_addr[1], 32'h0000_0000);
      end
    end

    do_req(1'b1, '{0, 2'd2, 0, 32'h0000_0006, 32'h0, 32'h0, 1, 1}, "trap lw mis");
    do_req(1'b1, '{0, 2'd2, 0, 32'h0000_0010, 32'h0, 32'h80FF_0000, 0, 3}, "trap lw aligned");

    // Response stall: hold rsp_ready low for 5 cycles.
    req_we = 1'b0; req_size = 2'd2; req_signed = 1'b0; req_addr = 32'h10;
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    n = 0;
    while (!a_rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("stall valid", 32'(a_rsp_valid), 32'd1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("stall%0d valid", k), 32'(a_rsp_valid), 32'd1);
      check($sformatf("stall%0d rdata", k), a_rsp_rdata, 32'h80FF_0000);
      check($sformatf("stall%0d exc/ready", k), {30'd0, a_rsp_exc, a_req_ready}, 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    check("stall release ready", 32'(a_req_ready), 32'd1);
    check("stall release valid", 32'(a_rsp_valid), 32'd0);

    // Reset in the second beat of a split load.
    req_we = 1'b0; req_size = 2'd2; req_signed = 1'b0; req_addr = 32'h0B;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    #1;
    check("mid B1 en", 32'(a_mem_en), 32'd1);
    check("mid B1 addr", a_mem_addr, 32'h0000_000C);
    reset_n = 1'b0;
    #1;
    check("mid rst ctl", {28'd0, a_mem_en, a_mem_we, a_rsp_valid, a_rsp_exc}, 32'd0);
    check("mid rst be", 32'(a_mem_be), 32'd0);
    check("mid rst addr", a_mem_addr, 32'd0);
    check("mid rst wdata", a_mem_wdata, 32'd0);
    check("mid rst rdata", a_rsp_rdata, 32'd0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    do_req(1'b0, '{0, 2'd2, 0, 32'h0000_0020, 32'h0, 32'hFE11_AB11, 0, 3}, "post-reset lw");
    do_req(1'b0, '{0, 2'd2, 0, 32'h0000_000B, 32'h0, 32'h1122_3344, 0, 4}, "post-reset split");

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
